// File: rtl/mul_div_pkg.sv
// Shared operation encodings for the single-cycle multiply/divide unit.
package mul_div_pkg;

  typedef enum logic [1:0] {
    OP_DIV   = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_MULTU = 2'b11
  } md_op_e;

endpackage

// File: rtl/mul_div_divu_core.sv
// Combinational unsigned restoring divider, fully unrolled one stage per quotient bit.
module divu_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // part[k] is the partial remainder after consuming the top k dividend bits.
  logic [WIDTH-1:0] part [WIDTH+1];

  assign part[0] = '0;

  // A zero divisor never borrows, so the quotient fills with ones and the
  // remainder ends up equal to the dividend without any special casing.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {part[gi], dividend[WIDTH-1-gi]};
    assign diff    = shifted - {1'b0, divisor};

    assign quotient[WIDTH-1-gi] = ~diff[WIDTH];
    assign part[gi+1]           = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  assign remainder = part[WIDTH];

endmodule

// File: rtl/mul_div.sv
// Single-cycle MULT/MULTU/DIV/DIVU with registered HI/LO results.
module mul_div
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       mdOp,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic [WIDTH-1:0] doutHi,
  output logic [WIDTH-1:0] doutLo
);

  md_op_e op;
  assign op = md_op_e'(mdOp[1:0]);

  logic is_mult_signed;
  logic is_div_signed;
  assign is_mult_signed = (op == OP_MULT);
  assign is_div_signed  = (op == OP_DIV);

  // Multiply: sign- or zero-extend to 2*WIDTH; low half of that product is exact.
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] product;

  assign mul_a   = {{WIDTH{is_mult_signed & din1[WIDTH-1]}}, din1};
  assign mul_b   = {{WIDTH{is_mult_signed & din2[WIDTH-1]}}, din2};
  assign product = mul_a * mul_b;

  // Divide: run magnitudes through the unsigned core, then restore signs.
  logic             a_neg;
  logic             b_neg;
  logic             div_by_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  assign a_neg       = is_div_signed & din1[WIDTH-1];
  assign b_neg       = is_div_signed & din2[WIDTH-1];
  assign div_by_zero = (din2 == '0);
  assign a_mag       = a_neg ? (~din1 + 1'b1) : din1;
  assign b_mag       = b_neg ? (~din2 + 1'b1) : din2;

  divu_core #(.WIDTH(WIDTH)) u_divu_core (
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (uq),
    .remainder (ur)
  );

  // MIN/-1 needs no special case: |MIN| wraps to MIN and negating it stays MIN.
  always_comb begin
    quot = uq;
    rem  = ur;
    if (div_by_zero) begin
      quot = '1;
      rem  = din1;
    end else begin
      if (a_neg ^ b_neg) quot = ~uq + 1'b1;
      if (a_neg)         rem  = ~ur + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      doutHi <= '0;
      doutLo <= '0;
    end else begin
      case (op)
        OP_MULT, OP_MULTU: begin
          doutHi <= product[2*WIDTH-1:WIDTH];
          doutLo <= product[WIDTH-1:0];
        end
        default: begin
          doutHi <= rem;
          doutLo <= quot;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div.sv
// Scoreboard bench for mul_div: directed vectors with hand-computed HI/LO.
module tb_mul_div;

  logic        clk;
  logic        rst;
  logic [3:0]  mdOp;
  logic [31:0] din1;
  logic [31:0] din2;
  logic [31:0] doutHi;
  logic [31:0] doutLo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  mul_div #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .mdOp   (mdOp),
    .din1   (din1),
    .din2   (din2),
    .doutHi (doutHi),
    .doutLo (doutLo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector on the falling edge; the next rising edge registers it.
  task automatic issue(input logic r, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input string name);
    exp_t e;
    @(negedge clk);
    rst  = r;
    mdOp = op;
    din1 = a;
    din2 = b;
    e.hi = hi;
    e.lo = lo;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge produces one result; compare it against the queue head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (doutHi !== e.hi || doutLo !== e.lo) begin
        bad++;
        $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h",
                 e.name, doutHi, doutLo, e.hi, e.lo);
      end else begin
        $display("txn %s: hi=%h lo=%h ok", e.name, doutHi, doutLo);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    mdOp  = 4'b0000;
    din1  = 32'h0;
    din2  = 32'h0;

    issue(1'b1, 4'b0011, 32'hABCD_CDEF, 32'h1234_5678, 32'h0, 32'h0, "reset");
    issue(1'b0, 4'b0000, 32'd5, 32'hFFFF_FFFD, 32'h0000_0002, 32'hFFFF_FFFF, "div_5_m3");
    issue(1'b0, 4'b0001, 32'd5, 32'd3, 32'h0000_0002, 32'h0000_0001, "divu_5_3");
    issue(1'b0, 4'b0010, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m5_3");
    issue(1'b0, 4'b0011, 32'hABCD_CDEF, 32'h1234_5678, 32'h0C37_9850, 32'h4E32_D208, "multu_big");
    issue(1'b0, 4'b0001, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_by0");
    issue(1'b0, 4'b0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf");
    issue(1'b0, 4'b0000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    issue(1'b0, 4'b0000, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, "div_m7_m2");
    issue(1'b0, 4'b0000, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_m7_by0");
    issue(1'b0, 4'b0001, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
    issue(1'b0, 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, "divu_big_div");
    issue(1'b0, 4'b0000, 32'h8000_0000, 32'd2, 32'h0, 32'hC000_0000, "div_min_2");
    issue(1'b0, 4'b0001, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'hFFFF_FFFF, "divu_max_1");
    issue(1'b0, 4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult_min_min");
    issue(1'b0, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    issue(1'b0, 4'b1110, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_rsvd_bits");
    issue(1'b0, 4'b0011, 32'hABCD_CDEF, 32'h1234_5678, 32'h0C37_9850, 32'h4E32_D208, "multu_pre_rst");
    issue(1'b1, 4'b0011, 32'hABCD_CDEF, 32'h1234_5678, 32'h0, 32'h0, "rst_override");
    issue(1'b0, 4'b0011, 32'hABCD_CDEF, 32'h1234_5678, 32'h0C37_9850, 32'h4E32_D208, "multu_after_rst");
    issue(1'b0, 4'b0010, 32'd0, 32'd0, 32'h0, 32'h0, "mult_zero");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
